// File: rtl/mmu_feeder_if.sv
// Tile-buffer write port, stream control and MMU-facing outputs of mmu_feeder.
// The testbench or upstream logic takes the master side; mmu_feeder takes the slave side.
interface mmu_feeder_if;
    logic        wr_en;
    logic        wr_sel;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        control;
    logic [31:0] wt_arr;
    logic [31:0] data_arr;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start,
        input  busy, done, control, wt_arr, data_arr
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start,
        output busy, done, control, wt_arr, data_arr
    );
endinterface

// File: rtl/mmu_feeder.sv
// Buffers a 4x4 int8 tile and streams it to a systolic MMU: weight load, data feed, drain, done.
// Define MMU_FEEDER_SKEW_EN to feed the A rows as a 7-cycle diagonal instead of 4 plain rows.
module mmu_feeder #(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    mmu_feeder_if.slave  bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD_WT = 3'd1;
    localparam logic [2:0] FEED    = 3'd2;
    localparam logic [2:0] DRAIN   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

`ifdef MMU_FEEDER_SKEW_EN
    localparam int FEED_LEN = 7;
`else
    localparam int FEED_LEN = 4;
`endif

    logic [2:0]  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] a_buf [4];
    logic [31:0] b_buf [4];

    logic        buf_we;
    logic [1:0]  wt_idx;
    logic [31:0] wt_sel;
    logic [31:0] feed_word;
    logic [3:0]  lane_t;

    logic        busy_q, done_q, control_q;
    logic [31:0] wt_q, data_q;

    assign buf_we = bus.wr_en && (state == IDLE);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = LOAD_WT;
                    cnt_nxt   = 4'd0;
                end
            end
            LOAD_WT: begin
                if (cnt == 4'd3) begin
                    state_nxt = FEED;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            FEED: begin
                if (cnt == 4'(FEED_LEN - 1)) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DRAIN: begin
                if (cnt == 4'(DRAIN_CYCLES - 1)) begin
                    state_nxt = DONE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // A B-column write landing on the start edge must already show up in the first weight beat.
    always_comb begin
        wt_idx = cnt_nxt[1:0];
        if (buf_we && bus.wr_sel && (bus.wr_addr == wt_idx)) begin
            wt_sel = bus.wr_data;
        end else begin
            wt_sel = b_buf[wt_idx];
        end
    end

    // Lane i carries element i of the A row due at step t (t - i when skewed).
    always_comb begin
        feed_word = 32'd0;
        lane_t    = 4'd0;
        for (int i = 0; i < 4; i++) begin
`ifdef MMU_FEEDER_SKEW_EN
            lane_t = cnt_nxt - 4'(i);
            if ((cnt_nxt >= 4'(i)) && (lane_t <= 4'd3)) begin
                feed_word[8*i +: 8] = a_buf[lane_t[1:0]][8*i +: 8];
            end
`else
            lane_t = cnt_nxt;
            feed_word[8*i +: 8] = a_buf[lane_t[1:0]][8*i +: 8];
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            control_q <= 1'b0;
            wt_q      <= 32'd0;
            data_q    <= 32'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            busy_q    <= (state_nxt != IDLE);
            done_q    <= (state_nxt == DONE);
            control_q <= (state_nxt == LOAD_WT);
            wt_q      <= (state_nxt == LOAD_WT) ? wt_sel : 32'd0;
            data_q    <= (state_nxt == FEED) ? feed_word : 32'd0;
        end
    end

    // NOTE: the tile buffers are reset too, since a start after reset must stream an all-zero tile.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                a_buf[i] <= 32'd0;
                b_buf[i] <= 32'd0;
            end
        end else if (buf_we) begin
            if (bus.wr_sel) begin
                b_buf[bus.wr_addr] <= bus.wr_data;
            end else begin
                a_buf[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.control  = control_q;
    assign bus.wt_arr   = wt_q;
    assign bus.data_arr = data_q;

endmodule

// File: tb/tb_mmu_feeder.sv
// Directed self-checking bench for mmu_feeder; expectations follow MMU_FEEDER_SKEW_EN when defined.
module tb_mmu_feeder;

    localparam int DRAIN = 4;
    localparam int NCYC  = 24;
`ifdef MMU_FEEDER_SKEW_EN
    localparam int FEED_LEN = 7;
`else
    localparam int FEED_LEN = 4;
`endif
    localparam int DONE_CYC = 4 + FEED_LEN + DRAIN + 1;

    logic clk;
    logic reset;

    mmu_feeder_if bus ();

    mmu_feeder #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_wt   [4];
    logic [31:0] exp_data [7];

    logic [2:0]  cap_flags [NCYC+1];
    logic [31:0] cap_wt    [NCYC+1];
    logic [31:0] cap_data  [NCYC+1];
    int          done_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic sel, input logic [1:0] addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = addr;
        bus.wr_data = data;
        step();
        bus.wr_en = 1'b0;
    endtask

    // Caller drives start (and any same-edge write) first; the next edge is cycle 0.
    task automatic stream(input int wr_cyc, input int start_cyc, input int rst_cyc);
        step();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        done_cnt  = 0;
        for (int c = 1; c <= NCYC; c++) begin
            cap_flags[c] = {bus.busy, bus.done, bus.control};
            cap_wt[c]    = bus.wt_arr;
            cap_data[c]  = bus.data_arr;
            if (bus.done) done_cnt++;
            if (c == wr_cyc) begin
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'b0;
                bus.wr_addr = 2'd0;
                bus.wr_data = 32'hFFFF_FFFF;
            end
            if (c == start_cyc) bus.start = 1'b1;
            if (c == rst_cyc) begin
                reset = 1'b1;
                #1;
                check("rst_mid_flags", {29'd0, bus.busy, bus.done, bus.control}, 32'd0);
                check("rst_mid_wt", bus.wt_arr, 32'd0);
                check("rst_mid_data", bus.data_arr, 32'd0);
            end
            if (rst_cyc > 0 && c == rst_cyc + 2) reset = 1'b0;
            step();
            bus.wr_en = 1'b0;
            bus.start = 1'b0;
        end
    endtask

    task automatic check_stream(input string tag);
        logic        e_ctrl, e_busy, e_done;
        logic [31:0] e_wt, e_data;
        for (int c = 1; c <= NCYC; c++) begin
            e_ctrl = (c >= 1 && c <= 4);
            e_wt   = e_ctrl ? exp_wt[c-1] : 32'd0;
            e_data = (c >= 5 && c < 5 + FEED_LEN) ? exp_data[c-5] : 32'd0;
            e_busy = (c <= DONE_CYC);
            e_done = (c == DONE_CYC);
            check($sformatf("%s_flags_c%0d", tag, c), {29'd0, cap_flags[c]},
                  {29'd0, e_busy, e_done, e_ctrl});
            check($sformatf("%s_wt_c%0d", tag, c), cap_wt[c], e_wt);
            check($sformatf("%s_data_c%0d", tag, c), cap_data[c], e_data);
        end
        check($sformatf("%s_done_count", tag), 32'(done_cnt), 32'd1);
    endtask

    initial begin
        exp_wt[0] = 32'h0000_0001;
        exp_wt[1] = 32'h0000_0100;
        exp_wt[2] = 32'h0001_0000;
        exp_wt[3] = 32'h0100_0000;
`ifdef MMU_FEEDER_SKEW_EN
        exp_data[0] = 32'h0000_0001;
        exp_data[1] = 32'h0000_0205;
        exp_data[2] = 32'h0003_0609;
        exp_data[3] = 32'h0407_0A0D;
        exp_data[4] = 32'h080B_0E00;
        exp_data[5] = 32'h0C0F_0000;
        exp_data[6] = 32'h1000_0000;
`else
        exp_data[0] = 32'h0403_0201;
        exp_data[1] = 32'h0807_0605;
        exp_data[2] = 32'h0C0B_0A09;
        exp_data[3] = 32'h100F_0E0D;
        exp_data[4] = 32'h0;
        exp_data[5] = 32'h0;
        exp_data[6] = 32'h0;
`endif

        // Writes and start during reset must be ignored.
        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 32'hDEAD_BEEF;
        step();
        step();
        step();
        check("reset_flags", {29'd0, bus.busy, bus.done, bus.control}, 32'd0);
        check("reset_wt", bus.wt_arr, 32'd0);
        check("reset_data", bus.data_arr, 32'd0);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        reset     = 1'b0;
        step();
        check("post_reset_idle", {29'd0, bus.busy, bus.done, bus.control}, 32'd0);

        write(1'b0, 2'd0, 32'h0403_0201);
        write(1'b0, 2'd1, 32'h0807_0605);
        write(1'b0, 2'd2, 32'h0C0B_0A09);
        write(1'b0, 2'd3, 32'h100F_0E0D);
        for (int k = 0; k < 4; k++) write(1'b1, 2'(k), exp_wt[k]);

        // Stream 1: write to A[0] while busy and a stray start at cycle 3, both ignored.
        bus.start = 1'b1;
        stream(2, 3, -1);
        check_stream("s1");

        // Stream 2: original A[0] survives; a start during the DONE cycle is not accepted.
        bus.start = 1'b1;
        stream(-1, DONE_CYC, -1);
        check_stream("s2");

        // Stream 3: B[2] written on the start edge is part of the streamed tile.
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b1;
        bus.wr_addr = 2'd2;
        bus.wr_data = 32'hAABB_CCDD;
        bus.start   = 1'b1;
        exp_wt[2]   = 32'hAABB_CCDD;
        stream(-1, -1, -1);
        check_stream("s3");

        // Stream 4: reset at cycle 7 aborts with no done pulse.
        bus.start = 1'b1;
        stream(-1, -1, 7);
        check("s4_done_count", 32'(done_cnt), 32'd0);
        for (int c = 8; c <= NCYC; c++) begin
            check($sformatf("s4_flags_c%0d", c), {29'd0, cap_flags[c]}, 32'd0);
            check($sformatf("s4_data_c%0d", c), cap_data[c], 32'd0);
        end

        // Stream 5: buffers were cleared by the reset, so everything streams as zero.
        for (int k = 0; k < 4; k++) exp_wt[k] = 32'd0;
        for (int k = 0; k < 7; k++) exp_data[k] = 32'd0;
        bus.start = 1'b1;
        stream(-1, -1, -1);
        check_stream("s5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmu_feeder.md
MMU_FEEDER -- requirements
Module: mmu_feeder

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 4, meaning the idle cycles after the last data beat before done; legal range 1..15.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port wr_en  input  1  tile-buffer write strobe.
REQ-005 The block SHALL have port wr_sel  input  1  0 = matrix A row buffer, 1 = matrix B column buffer.
REQ-006 The block SHALL have port wr_addr  input  2  row index (A) or column index (B).
REQ-007 The block SHALL have port wr_data  input  32  four signed 8-bit elements; element j in bits [8j+7:8j].
REQ-008 The block SHALL have port start  input  1  single-cycle request to stream the buffered tile.
REQ-009 The block SHALL have port busy  output  1  high while a tile is streaming.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse at stream completion.
REQ-011 The block SHALL have port control  output  1  MMU mode: 1 = weight load, 0 = data feed.
REQ-012 The block SHALL have port wt_arr  output  32  weight column to the MMU.
REQ-013 The block SHALL have port data_arr  output  32  data lanes to the MMU; lane i in bits [8i+7:8i].

Function
REQ-014 Buffers SHALL be 4x32-bit A and 4x32-bit B register files, written on a clk edge when wr_en=1 and the FSM is in IDLE.
REQ-015 wr_en outside IDLE SHALL be ignored; the buffers are unchanged.
REQ-016 FSM states SHALL be IDLE, LOAD_WT, FEED, DRAIN, DONE.
REQ-017 IDLE -> LOAD_WT on an edge with start=1; start outside IDLE SHALL be ignored.
REQ-018 A write and start on the same edge in IDLE SHALL both take effect, and the streamed tile SHALL include that write.
REQ-019 Take the start edge as cycle 0. In LOAD_WT (cycles 1-4), outputs SHALL be control=1 and wt_arr=B[k] on cycle k+1, with data_arr=0.
REQ-020 In FEED, control=0 and wt_arr=0; with skew (REQ-030), FEED SHALL last 7 cycles (t=0..6), where lane i = A[t-i] element i if 0<=t-i<=3, else 0.
REQ-021 In DRAIN, control=0 and data_arr=wt_arr=0 for DRAIN_CYCLES cycles, then DONE for one cycle, then IDLE.
REQ-022 busy SHALL be 1 from cycle 1 through the DONE cycle inclusive; done=1 only in the DONE cycle.
REQ-023 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-024 start accepted on the edge where DONE returns to IDLE is not possible; a new start SHALL be accepted only from the first IDLE cycle.

Reset
REQ-025 While reset=1, the FSM SHALL be IDLE, all buffers 0, and busy=done=control=0, wt_arr=data_arr=0, asynchronously.
REQ-026 Reset mid-stream SHALL abort immediately with no done pulse; after release, the block SHALL wait in IDLE for new writes and start.
REQ-027 wr_en and start asserted during reset SHALL have no effect.

Configuration
REQ-028 Macro MMU_FEEDER_SKEW_EN SHALL select input skewing.
REQ-029 MMU_FEEDER_SKEW_EN undefined: FEED SHALL last 4 cycles, with data_arr=A[t] unskewed; done then occurs at cycle 8+DRAIN_CYCLES+1.
REQ-030 MMU_FEEDER_SKEW_EN defined: FEED SHALL be the 7-cycle diagonal of REQ-020; done occurs at cycle 11+DRAIN_CYCLES+1 (cycle 16 at default).

Verification
REQ-031 Skew on, A rows 0x04030201/0x08070605/0x0C0B0A09/0x100F0E0D, B=identity columns, start -> cycles 1-4: control=1, wt_arr=0x00000001,0x00000100,0x00010000,0x01000000; cycle 5: data_arr=0x00000001; cycle 6: 0x00000205; cycle 11: 0x10000000; done at cycle 16.
REQ-032 Skew off, same tile -> data_arr=0x04030201..0x100F0E0D on cycles 5-8; done at cycle 13.
REQ-033 wr_en to A[0]=0xFFFFFFFF while busy, then a second start after done -> the second stream shows the original A[0], unmodified.
REQ-034 start pulsed at cycle 3 of a stream -> no restart; exactly one done pulse, at cycle 16.
REQ-035 reset asserted at cycle 7 -> all outputs 0 immediately, no done pulse; buffers read 0 on the next start.
REQ-036 Write B[2]=0xAABBCCDD together with start on the same edge -> wt_arr=0xAABBCCDD on cycle 3.
